bcd_display_driver: RTL and testbench
=====================================

// Module: bcd_display_driver
// PURPOSE
//  Downstream stage of the single-digit BCD adder. Latches the adder's
//  {finalcarry, sum} result on a valid/ready handshake. Shows it as two
//  time-multiplexed 7-segment digits: tens = finalcarry, ones = sum.
//  Holds each accepted result for a minimum time, then accepts the next.
//  Flags non-BCD sums (>9) arriving from upstream.
// PARAMETERS
//  REFRESH_DIV  4  cycles each digit slot is lit before switching (>=1)
//  HOLD_CYCLES  8  cycles in_ready stays low after an accept (0 = never low)
// PORTS
//  clk         in   1  single clock, all state on rising edge
//  rst         in   1  synchronous, active-high reset
//  in_valid    in   1  upstream result valid
//  in_ready    out  1  block can accept a result this cycle
//  sum         in   4  BCD ones digit from adder
//  finalcarry  in   1  tens digit (0/1) from adder
//  seg         out  7  segments, active-high, seg[0]=a ... seg[6]=g
//  an          out  2  digit enable, one-hot active-high; 01=ones, 10=tens
//  err         out  1  latched sum was not valid BCD
// BEHAVIOUR
//  - Reset (rst high at an edge): all state is cleared and outputs return
//    to reset values on that edge, regardless of any operation in progress.
//    - ones=0, tens=0, err=0, refresh cnt=0, hold cnt=0.
//    - state=SHOW_ONES, an=01, seg=7'h3F, in_ready=1.
//  - Outputs depend only on registers; there is no combinational path
//    from any input to any output.
//  - Accept: the edge where in_valid && in_ready are both high.
//    - ones<=sum, tens<=finalcarry, err<=(sum>9).
//    - The new digits are visible on seg in the cycle after that edge.
//  - Hold: an accept loads hold cnt=HOLD_CYCLES.
//    - in_ready = (hold cnt==0); hold cnt decrements to 0 and saturates.
//    - in_ready is therefore low for exactly HOLD_CYCLES cycles.
//    - HOLD_CYCLES=0: in_ready stays 1 and back-to-back accepts are legal.
//  - in_valid while in_ready=0: ignored; nothing is latched. Upstream
//    must hold its data until the accept.
//  - Display FSM states: SHOW_ONES (an=01), SHOW_TENS (an=10).
//    - The refresh cnt counts 0..REFRESH_DIV-1.
//    - At REFRESH_DIV-1 the state toggles and the cnt wraps to 0.
//    - Each slot is lit for exactly REFRESH_DIV cycles.
//    - REFRESH_DIV=1: the state toggles every cycle.
//  - An accept does not affect the FSM or the refresh cnt. If an accept
//    coincides with a slot toggle, both take effect on the same edge.
//  - Decode, active slot digit d:
//    0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
//  - err=1: both slots show 'E' (7'h79).
//    - err stays set until the next accept of a valid BCD sum clears it.
//  - sum=9 with finalcarry=1 is displayed as "19"; the range is not
//    checked beyond sum>9.
// CONFIGURATION
//  BLANK_LEADING_ZERO_EN
//   - Defined: when state=SHOW_TENS, tens=0 and err=0, seg=7'h00.
//     an still reads 10, so the slot timing is unchanged.
//   - Undefined: the tens slot always shows its digit, so 0 displays 7'h3F.
// TESTING
//  1. rst=1 for 2 cycles, then release -> an=01, seg=3F, in_ready=1,
//     err=0; an toggles to 10 after 4 cycles.
//  2. Accept sum=7, finalcarry=1 -> ones slot seg=07, tens slot seg=06;
//     each slot is held for exactly 4 cycles.
//  3. Accept sum=3, then hold in_valid with sum=5 -> in_ready low for
//     exactly 8 cycles; sum=5 is accepted on the first edge with
//     in_ready=1; ones seg goes 4F then 6D.
//  4. Accept sum=4'hC, finalcarry=0 -> err=1, both slots seg=79.
//     Next accept of sum=2 -> err=0, ones seg=5B.
//  5. Assert rst 3 cycles into a hold window, in the tens slot ->
//     next cycle in_ready=1, an=01, seg=3F, err=0.
//  6. Accept sum=5, finalcarry=0 -> tens slot seg=00 with the macro
//     defined, seg=3F without it; ones slot seg=6D in both builds.

Source files
------------

// File: rtl/bcd_display_driver.sv
// rtl/bcd_display_driver.sv - latches BCD adder results and multiplexes them onto two 7-segment digits
// Optional feature macro: BLANK_LEADING_ZERO_EN (blanks a zero tens digit).
module bcd_display_driver #(
    parameter int REFRESH_DIV = 4,
    parameter int HOLD_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] sum,
    input  logic       finalcarry,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       err
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [HW-1:0] HOLD_LOAD    = HW'(HOLD_CYCLES);
    localparam logic [6:0]    SEG_E        = 7'h79;

    typedef enum logic {
        SHOW_ONES = 1'b0,
        SHOW_TENS = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   refresh_cnt_q, refresh_cnt_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [3:0]      ones_q, ones_d;
    logic            tens_q, tens_d;
    logic            err_q, err_d;
    logic            accept;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= SHOW_ONES;
            refresh_cnt_q <= '0;
            hold_cnt_q    <= '0;
            ones_q        <= 4'd0;
            tens_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            refresh_cnt_q <= refresh_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            ones_q        <= ones_d;
            tens_q        <= tens_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        refresh_cnt_d = refresh_cnt_q + 1'b1;
        hold_cnt_d    = hold_cnt_q;
        ones_d        = ones_q;
        tens_d        = tens_q;
        err_d         = err_q;
        accept        = in_valid && (hold_cnt_q == '0);

        // Slot timing runs freely; accepts never disturb it.
        if (refresh_cnt_q == REFRESH_LAST) begin
            refresh_cnt_d = '0;
            state_d       = (state_q == SHOW_ONES) ? SHOW_TENS : SHOW_ONES;
        end

        if (accept) begin
            ones_d     = sum;
            tens_d     = finalcarry;
            err_d      = (sum > 4'd9);
            hold_cnt_d = HOLD_LOAD;
        end else if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - 1'b1;
        end

        in_ready = (hold_cnt_q == '0);
        err      = err_q;
        an       = (state_q == SHOW_ONES) ? 2'b01 : 2'b10;

        if (err_q) begin
            seg = SEG_E;
        end else if (state_q == SHOW_ONES) begin
            seg = seg_decode(ones_q);
        end else begin
`ifdef BLANK_LEADING_ZERO_EN
            seg = tens_q ? seg_decode(4'd1) : 7'h00;
`else
            seg = seg_decode({3'b000, tens_q});
`endif
        end
    end

endmodule

// File: tb/tb_bcd_display_driver.sv
// tb/tb_bcd_display_driver.sv - randomized bench for bcd_display_driver against a cycle-count reference model
module tb_bcd_display_driver;

    localparam int REFRESH_DIV = 4;
    localparam int HOLD_CYCLES = 8;
    localparam int N_CYCLES    = 3000;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] sum;
    logic       finalcarry;
    logic [6:0] seg;
    logic [1:0] an;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: everything derived from edges since the last reset.
    int         m_edges;
    bit         m_have_acc;
    int         m_last_acc;
    int         m_ones;
    int         m_tens;
    bit         m_err;
    logic [6:0] dec_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    bcd_display_driver #(
        .REFRESH_DIV(REFRESH_DIV),
        .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sum        (sum),
        .finalcarry (finalcarry),
        .seg        (seg),
        .an         (an),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, m_edges, got, exp);
        end
    endtask

    function automatic bit m_ready();
        return !m_have_acc || ((m_edges - m_last_acc) >= HOLD_CYCLES);
    endfunction

    function automatic int m_slot();
        return (m_edges / REFRESH_DIV) % 2;
    endfunction

    function automatic logic [6:0] m_seg();
        if (m_err) return 7'h79;
        if (m_slot() == 0) return dec_tab[m_ones];
`ifdef BLANK_LEADING_ZERO_EN
        if (m_tens == 0) return 7'h00;
`endif
        return dec_tab[m_tens];
    endfunction

    task automatic model_reset();
        m_edges    = 0;
        m_have_acc = 1'b0;
        m_last_acc = 0;
        m_ones     = 0;
        m_tens     = 0;
        m_err      = 1'b0;
    endtask

    initial begin
        bit acc;
        rst        = 1'b1;
        in_valid   = 1'b1;
        sum        = 4'd7;
        finalcarry = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();

        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(negedge clk);
            check("an",       32'(an),       32'(m_slot() == 0 ? 2'b01 : 2'b10));
            check("seg",      32'(seg),      32'(m_seg()));
            check("in_ready", 32'(in_ready), 32'(m_ready()));
            check("err",      32'(err),      32'(m_err));

            in_valid   = ($urandom_range(0, 1) == 1);
            sum        = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15))
                                                     : 4'($urandom_range(0, 9));
            finalcarry = 1'($urandom_range(0, 1));

            if (cyc == 1000 || $urandom_range(0, 249) == 0) begin
                rst = 1'b1;
                @(posedge clk);
                model_reset();
            end else begin
                rst = 1'b0;
                acc = in_valid && m_ready();
                @(posedge clk);
                m_edges++;
                if (acc) begin
                    m_have_acc = 1'b1;
                    m_last_acc = m_edges;
                    m_ones     = int'(sum);
                    m_tens     = int'(finalcarry);
                    m_err      = (sum > 4'd9);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
